// File: rtl/sdram_test_pkg.sv
// Shared types and LFSR definitions for the SDRAM memory-test traffic generators.
package sdram_test_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, FIN} state_t;

  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/sdram_wb_memtest_if.sv
// Wishbone classic bus bundle between a traffic master and an arbiter port.
interface if_wb #(
  parameter int AWIDTH = 26,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0]   adr;
  logic [DWIDTH-1:0]   dat_m;
  logic [DWIDTH-1:0]   dat_s;
  logic                we;
  logic [DWIDTH/8-1:0] sel;
  logic                cyc;
  logic                stb;
  logic                ack;

  modport master (output adr, dat_m, we, sel, cyc, stb, input dat_s, ack);
  modport slave  (input adr, dat_m, we, sel, cyc, stb, output dat_s, ack);
endinterface

// File: rtl/sdram_wb_memtest_lfsr32.sv
// 32-bit Galois LFSR with synchronous load and advance; a zero seed loads the default.
module lfsr32
  import sdram_test_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        value <= LFSR_SEED_DEFAULT;
    else if (load)    value <= (seed == 32'h0) ? LFSR_SEED_DEFAULT : seed;
    else if (advance) value <= lfsr_step(value);
  end

endmodule

// File: rtl/sdram_wb_memtest.sv
// Wishbone memory tester: writes a pattern over a word range, reads it back and
// reports mismatches. Also serves as a traffic source for arbitration stress tests.
module sdram_wb_memtest
  import sdram_test_pkg::*;
#(
  parameter int AWIDTH = 26,
  parameter int DWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.master              bus,
  input  logic              start,
  input  logic              abort,
  input  logic [AWIDTH-1:0] base_adr,
  input  logic [AWIDTH-1:0] length,
  input  logic              mode,
  input  logic [DWIDTH-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              aborted,
  output logic [CWIDTH-1:0] err_count,
  output logic [AWIDTH-1:0] err_adr,
  output logic [DWIDTH-1:0] err_exp,
  output logic [DWIDTH-1:0] err_got
);

  state_t            state;
  logic [AWIDTH-1:0] base_r, len_r, cnt;
  logic              mode_r, abort_pend;
  logic [31:0]       seed_r, seed_fix, lfsr_seed, lfsr_val;
  logic              lfsr_load, lfsr_adv, abort_req, last_word;
  logic [DWIDTH-1:0] exp_pat;

  function automatic logic [DWIDTH-1:0] pat_of(input logic m, input logic [31:0] l,
                                               input logic [AWIDTH-1:0] a);
    return m ? DWIDTH'(l) : DWIDTH'(a);
  endfunction

  always_comb begin
    seed_fix  = (32'(seed) == 32'h0) ? LFSR_SEED_DEFAULT : 32'(seed);
    lfsr_seed = (state == IDLE) ? seed_fix : seed_r;
    lfsr_load = ((state == IDLE) && start && (length != '0)) || (state == GAP);
    lfsr_adv  = bus.ack && bus.stb && ((state == WRITE) || (state == READ));
    abort_req = abort || abort_pend;
    last_word = (cnt == AWIDTH'(1));
    exp_pat   = pat_of(mode_r, lfsr_val, bus.adr);
  end

  lfsr32 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .seed    (lfsr_seed),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      bus.cyc    <= 1'b0;
      bus.stb    <= 1'b0;
      bus.we     <= 1'b0;
      bus.adr    <= '0;
      bus.dat_m  <= '0;
      bus.sel    <= '1;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      aborted    <= 1'b0;
      err_count  <= '0;
      err_adr    <= '0;
      err_exp    <= '0;
      err_got    <= '0;
      base_r     <= '0;
      len_r      <= '0;
      cnt        <= '0;
      mode_r     <= 1'b0;
      seed_r     <= LFSR_SEED_DEFAULT;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort is honoured only at an ack or between accesses, so remember it until then
      if (state != IDLE && abort) abort_pend <= 1'b1;
      case (state)
        IDLE: if (start) begin
          busy       <= 1'b1;
          pass       <= 1'b0;
          aborted    <= 1'b0;
          err_count  <= '0;
          err_adr    <= '0;
          err_exp    <= '0;
          err_got    <= '0;
          abort_pend <= 1'b0;
          if (length == '0) begin
            state <= FIN;
          end else begin
            base_r    <= base_adr;
            len_r     <= length;
            cnt       <= length;
            mode_r    <= mode;
            seed_r    <= seed_fix;
            bus.adr   <= base_adr;
            bus.dat_m <= pat_of(mode, seed_fix, base_adr);
            bus.cyc   <= 1'b1;
            bus.stb   <= 1'b1;
            bus.we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: if (bus.ack) begin
          cnt       <= cnt - AWIDTH'(1);
          bus.adr   <= bus.adr + AWIDTH'(1);
          bus.dat_m <= pat_of(mode_r, lfsr_step(lfsr_val), bus.adr + AWIDTH'(1));
          if (abort_req || last_word) begin
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
            bus.we  <= 1'b0;
            aborted <= abort_req;
            state   <= abort_req ? FIN : GAP;
          end
        end
        GAP: begin
          if (abort_req) begin
            aborted <= 1'b1;
            state   <= FIN;
          end else begin
            bus.adr <= base_r;
            cnt     <= len_r;
            bus.cyc <= 1'b1;
            bus.stb <= 1'b1;
            state   <= READ;
          end
        end
        READ: if (bus.ack) begin
          if (bus.dat_s != exp_pat) begin
            if (err_count != '1) err_count <= err_count + CWIDTH'(1);
            if (err_count == '0) begin
              err_adr <= bus.adr;
              err_exp <= exp_pat;
              err_got <= bus.dat_s;
            end
          end
          cnt     <= cnt - AWIDTH'(1);
          bus.adr <= bus.adr + AWIDTH'(1);
          if (abort_req || last_word) begin
            bus.cyc <= 1'b0;
            bus.stb <= 1'b0;
            aborted <= abort_req;
            state   <= FIN;
          end
        end
        FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          pass       <= (err_count == '0) && !aborted;
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_wb_memtest.md
Name: sdram_wb_memtest

Overview:
- Wishbone bus initiator (master) that exercises the SDRAM path by issuing transactions into an arbiter input of the SDRAM controller.
- Phase 1 writes a generated pattern over an address range; phase 2 reads the range back, regenerates the pattern and compares.
- Reports pass/fail, error count and first failing address/data.
- Used for board bring-up and as a traffic source when stress-testing arbitration against the CPU port.

Parameters:
- AWIDTH, 26, bus address width (word address).
- DWIDTH, 32, bus data width.
- CWIDTH, 16, width of error counter (saturating).

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- bus  if_wb.master  -  Wishbone master port (adr, dat_m, dat_s, we, sel, cyc, stb, ack).
- start  input  1  one-cycle pulse; sampled only in IDLE.
- abort  input  1  level; terminates the test at the next safe point.
- base_adr  input  AWIDTH  first word address; latched on start.
- length  input  AWIDTH  number of words; latched on start; 0 means no-op.
- mode  input  1  0 = pattern is the address (zero-extended/truncated to DWIDTH); 1 = 32-bit LFSR pattern; latched on start.
- seed  input  DWIDTH  LFSR seed; latched on start; all-zero seed replaced by 32'h1.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  valid from done until the next start: err_count == 0 and not aborted.
- aborted  output  1  sticky until the next start.
- err_count  output  CWIDTH  mismatches; saturates at all-ones.
- err_adr  output  AWIDTH  address of the first mismatch.
- err_exp, err_got  output  DWIDTH  expected and read data of the first mismatch.

Behaviour:
- Reset: bus.cyc = bus.stb = bus.we = 0; bus.adr, bus.dat_m = 0; bus.sel = all-ones; all outputs 0; state IDLE.

States:
- IDLE: on start with length != 0, latch inputs, clear results, go to WRITE. On start with length == 0, go to FIN.
- WRITE: cyc = stb = we = 1, adr = current address, dat_m = current pattern. Hold all outputs stable until ack.
  - On ack: advance address (+1, wraps modulo 2^AWIDTH) and the pattern generator.
  - After the last word, go to GAP.
- GAP: cyc = stb = 0 for exactly one cycle so the arbiter can re-grant. Reset address to base and LFSR to seed. Go to READ.
- READ: cyc = stb = 1, we = 0. On ack, compare dat_s with the pattern.
  - On mismatch: increment err_count (saturating).
  - On the first mismatch only: capture err_adr, err_exp and err_got.
  - Advance address and pattern; after the last word, go to FIN.
- FIN: cyc = stb = 0, pulse done, set pass, go to IDLE.

Timing and handshake:
- Transaction timing: cyc/stb rise the cycle after entering WRITE/READ. Each access completes on the ack cycle. The next access is presented the following cycle without dropping cyc within a phase: back-to-back, 1 word per cycle best case. stb is never deasserted before ack.
- LFSR: Galois form, polynomial x^32+x^22+x^2+x+1. Advanced once per acked word in both phases, so read-phase expected values equal written values. For DWIDTH != 32 the pattern is truncated to DWIDTH.

Abort and boundary cases:
- abort: if asserted while no access is outstanding or on an ack cycle, finish that access, then go to FIN with aborted = 1 and pass = 0. A bus access is never abandoned mid-handshake.
- start while busy: ignored.
- Address wrap: base + length past 2^AWIDTH wraps to 0; no error is raised.
- Reset mid-transaction: cyc/stb drop asynchronously; no done pulse.
- Word count: a word counter of AWIDTH bits tracks remaining words; the last word is when the counter equals 1.

Decomposition:
- Package sdram_test_pkg: state enum (IDLE, WRITE, GAP, READ, FIN), LFSR polynomial constant, nonzero-seed default constant.
- Sub-module lfsr32: load, advance, value; it is reused by future traffic generators.

Test Plan:
- Memory model acks in 1 cycle; base = 0x100, length = 4, mode 0 -> writes 0x100..0x103 with data equal to the address; reads match; done after 4 + 1 + 4 + 1 access cycles; pass = 1, err_count = 0.
- mode 1, seed 0x1, length 8, model ack latency 3 -> written data sequence equals the lfsr32 reference model; pass = 1; stb is held across every wait cycle.
- Model corrupts word at 0x102 (XOR 0x1) and 0x105 on read; base 0x100, length 8 -> err_count = 2, err_adr = 0x102, err_exp/err_got captured for 0x102 only, pass = 0.
- abort raised during the 3rd write with ack latency 2 -> that write completes, no further stb, done pulses, aborted = 1, pass = 0.
- length = 0 -> no cyc ever asserted, done two cycles after start, pass = 1. Separately, base = 2^26 - 2, length = 4 -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1.
- rst_i asserted mid-READ -> cyc/stb/busy low in the same cycle with no clock edge; a later start runs normally with fresh results.
